fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters, 2..8.
REQ-002 Parameter WIDTH, default 8: data width per requester and to the FIFO.
REQ-003 Parameter BURST_LEN, default 16: maximum beats per grant, 1..255.
REQ-004 Parameter ID_W, default $clog2(NUM_REQ): requester index width.
REQ-005 clk_in  input  1  write-domain clock; all logic on rising edge.
REQ-006 rst_in_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  NUM_REQ  per-requester data-valid.
REQ-008 req_data  input  NUM_REQ*WIDTH  per-requester data; requester i at bits [i*WIDTH +: WIDTH].
REQ-009 req_ready  output  NUM_REQ  per-requester accept strobe.
REQ-010 fifo_full  input  1  full flag from the async FIFO write port.
REQ-011 fifo_we  output  1  FIFO write enable.
REQ-012 fifo_data  output  WIDTH  FIFO write data.
REQ-013 grant_id  output  ID_W  index of the currently granted requester.
REQ-014 busy  output  1  high while in GRANT state.
REQ-015 beat_cnt  output  8  beats transferred in the current grant.

Function
REQ-016 FSM has two states, IDLE and GRANT; state, grant_id, beat_cnt and the round-robin pointer last_id are registers.
REQ-017 IDLE: if any req_valid bit is high, select the first valid index searching upward from last_id+1 modulo NUM_REQ, load it into grant_id, clear beat_cnt, and enter GRANT next cycle; otherwise remain in IDLE.
REQ-018 IDLE: req_ready and fifo_we are 0 (one arbitration bubble per grant).
REQ-019 GRANT: req_ready[grant_id] = !fifo_full; every other req_ready bit is 0; all combinational.
REQ-020 GRANT: fifo_we = req_valid[grant_id] && !fifo_full; fifo_data = req_data[grant_id] unconditionally.
REQ-021 A beat is a cycle in GRANT with fifo_we = 1; each beat increments beat_cnt by 1.
REQ-022 Grant release, GRANT to IDLE next cycle: (a) a beat occurs with beat_cnt == BURST_LEN-1, or (b) req_valid[grant_id] is 0 in that cycle.
REQ-023 fifo_full high with req_valid[grant_id] high: no beat, no release, beat_cnt holds; the grant stalls indefinitely.
REQ-024 On release, last_id <= grant_id; beat_cnt holds its final value until the next IDLE-to-GRANT load clears it.
REQ-025 Valid bits of non-granted requesters have no effect during GRANT; requesters hold data and valid until ready.
REQ-026 fifo_we never asserts while fifo_full is 1, in any state.
REQ-027 NUM_REQ not a power of two: index arithmetic wraps at NUM_REQ, never at 2**ID_W.

Reset
REQ-028 rst_in_n low forces state = IDLE, grant_id = 0, beat_cnt = 0, last_id = NUM_REQ-1, so requester 0 has first priority; combinational outputs follow: req_ready = 0, fifo_we = 0, busy = 0.
REQ-029 Reset asserted mid-grant aborts the burst immediately; no beat occurs in any cycle where rst_in_n is low.
REQ-030 After deassertion, first arbitration happens on the first rising edge with rst_in_n high.

Verification
REQ-031 Single requester: req_valid = 4'b0100, 20 words, full = 0 -> bubble, beats 0..15 with grant_id = 2, IDLE, bubble, 4 more beats; FIFO order preserved.
REQ-032 Round-robin: all four valid continuously, BURST_LEN = 2 -> grant_id sequence 0,1,2,3,0; each grant exactly 2 beats.
REQ-033 Backpressure: fifo_full high 5 cycles mid-burst -> fifo_we = 0 and req_ready = 0 those cycles; beat_cnt holds; no data lost or duplicated.
REQ-034 Early release: granted requester drops valid after 3 beats -> beat_cnt = 3, next owner is the next valid index above it.
REQ-035 Reset mid-burst at beat_cnt = 7 -> all outputs 0 same cycle; after release requester 0 wins if valid.
REQ-036 NUM_REQ = 3: valid = 3'b101 with last_id = 2 -> grant 0, then 2, then 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that merges NUM_REQ write requesters
// into a single async-FIFO write port, granting bursts of up to BURST_LEN beats.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                     clk_in,
  input  logic                     rst_in_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_we,
  output logic [WIDTH-1:0]         fifo_data,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic [7:0]               beat_cnt
);

  localparam int unsigned CNT_W = 8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]  RST_LAST  = ID_W'(NUM_REQ - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [ID_W-1:0]  r_grant_id;
  logic [ID_W-1:0]  r_last_id;
  logic [CNT_W-1:0] r_beat_cnt;

  logic             w_hi_found;
  logic             w_lo_found;
  logic [ID_W-1:0]  w_hi_id;
  logic [ID_W-1:0]  w_lo_id;
  logic             w_any_valid;
  logic [ID_W-1:0]  w_next_id;
  logic             w_sel_valid;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_busy;
  logic             w_beat;
  logic             w_release;

  // Round-robin pick: lowest valid index above r_last_id, else lowest valid
  // index at or below it. Wraps at NUM_REQ regardless of 2**ID_W.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_id    = '0;
    w_lo_id    = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (ID_W'(i) > r_last_id) begin
          w_hi_found = 1'b1;
          w_hi_id    = ID_W'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_id    = ID_W'(i);
        end
      end
    end
    w_any_valid = w_hi_found | w_lo_found;
    w_next_id   = w_hi_found ? w_hi_id : w_lo_id;
  end

  // Select valid/data of the granted requester.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (r_grant_id == ID_W'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_busy    = (r_state == GRANT);
  assign w_beat    = w_busy && w_sel_valid && !fifo_full;
  assign w_release = w_busy && (!w_sel_valid || (w_beat && (r_beat_cnt == LAST_BEAT)));

  // Ready strobe only toward the granted requester, gated by FIFO space.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_ready[i] = w_busy && !fifo_full && (r_grant_id == ID_W'(i));
    end
  end

  assign fifo_we   = w_beat;
  assign fifo_data = w_sel_data;
  assign busy      = w_busy;
  assign grant_id  = r_grant_id;
  assign beat_cnt  = r_beat_cnt;

  // State register.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: IDLE arbitrates for one cycle, GRANT runs until release.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE) begin
      if (w_any_valid) begin
        w_state_nxt = GRANT;
      end
    end else begin
      if (w_release) begin
        w_state_nxt = IDLE;
      end
    end
  end

  // Grant owner, beat counter and round-robin pointer.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_last_id  <= RST_LAST;
    end else begin
      if (!w_busy && w_any_valid) begin
        r_grant_id <= w_next_id;
        r_beat_cnt <= '0;
      end
      if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
      if (w_release) begin
        r_last_id <= r_grant_id;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter with three instances
// (default config, BURST_LEN=2, and NUM_REQ=3 with BURST_LEN=2).
module tb_fifo_wr_arbiter;

  logic clk_in = 1'b0;
  logic rst_in_n;

  always #5 clk_in = ~clk_in;

  logic [3:0]  a_valid, a_ready;
  logic [31:0] a_data;
  logic        a_full, a_we, a_busy;
  logic [7:0]  a_fdata, a_bc;
  logic [1:0]  a_gid;

  logic [3:0]  b_valid, b_ready;
  logic [31:0] b_data;
  logic        b_full, b_we, b_busy;
  logic [7:0]  b_fdata, b_bc;
  logic [1:0]  b_gid;

  logic [2:0]  c_valid, c_ready;
  logic [23:0] c_data;
  logic        c_full, c_we, c_busy;
  logic [7:0]  c_fdata, c_bc;
  logic [1:0]  c_gid;

  int total = 0;
  int bad   = 0;
  int idx;
  int ph;
  int g;
  logic e_we, e_busy;
  logic [1:0] ord [3];

  fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .BURST_LEN(16)) u_dut_a (
    .clk_in(clk_in), .rst_in_n(rst_in_n),
    .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
    .fifo_full(a_full), .fifo_we(a_we), .fifo_data(a_fdata),
    .grant_id(a_gid), .busy(a_busy), .beat_cnt(a_bc)
  );

  fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .BURST_LEN(2)) u_dut_b (
    .clk_in(clk_in), .rst_in_n(rst_in_n),
    .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
    .fifo_full(b_full), .fifo_we(b_we), .fifo_data(b_fdata),
    .grant_id(b_gid), .busy(b_busy), .beat_cnt(b_bc)
  );

  fifo_wr_arbiter #(.NUM_REQ(3), .WIDTH(8), .BURST_LEN(2)) u_dut_c (
    .clk_in(clk_in), .rst_in_n(rst_in_n),
    .req_valid(c_valid), .req_data(c_data), .req_ready(c_ready),
    .fifo_full(c_full), .fifo_we(c_we), .fifo_data(c_fdata),
    .grant_id(c_gid), .busy(c_busy), .beat_cnt(c_bc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in_n = 1'b0;
    a_valid  = 4'b0100;
    a_data   = 32'h0040_0000;
    a_full   = 1'b0;
    b_valid  = '0;
    b_data   = 32'hD3D2_D1D0;
    b_full   = 1'b0;
    c_valid  = '0;
    c_data   = 24'hC2C1C0;
    c_full   = 1'b0;
    ord[0]   = 2'd0;
    ord[1]   = 2'd2;
    ord[2]   = 2'd0;

    // Reset state, with a requester already valid.
    #1;
    chk("rst_we",    a_we,    0);
    chk("rst_ready", a_ready, 0);
    chk("rst_busy",  a_busy,  0);
    chk("rst_gid",   a_gid,   0);
    chk("rst_bc",    a_bc,    0);
    @(posedge clk_in); #1;
    chk("rst_hold_busy", a_busy, 0);
    chk("rst_hold_we",   a_we,   0);
    @(posedge clk_in); #1;
    rst_in_n = 1'b1;

    // Single requester 2, 20 words: bubble, 16 beats, bubble, 4 beats.
    idx = 0;
    for (int c = 0; c <= 23; c++) begin
      a_valid        = (idx < 20) ? 4'b0100 : 4'b0000;
      a_data[23:16]  = 8'h40 + 8'(idx);
      e_we   = (c >= 1 && c <= 16) || (c >= 18 && c <= 21);
      e_busy = (c >= 1 && c <= 16) || (c >= 18 && c <= 22);
      #1;
      chk("t1_we",    a_we,    e_we);
      chk("t1_busy",  a_busy,  e_busy);
      chk("t1_ready", a_ready, e_busy ? 4'b0100 : 4'b0000);
      chk("t1_bc",    a_bc,    (c <= 17) ? idx : idx - 16);
      if (e_busy) chk("t1_gid", a_gid, 2);
      if (e_we) begin
        chk("t1_data", a_fdata, 8'h40 + 8'(idx));
        idx++;
      end
      @(posedge clk_in); #1;
    end

    // Round-robin with BURST_LEN=2: grants 0,1,2,3,0, two beats each.
    b_valid = 4'b1111;
    for (int c = 0; c <= 14; c++) begin
      ph   = c % 3;
      g    = (c / 3) % 4;
      e_we = (ph != 0);
      #1;
      chk("rr_we",   b_we,   e_we);
      chk("rr_busy", b_busy, e_we);
      if (e_we) begin
        chk("rr_gid",   b_gid,   g);
        chk("rr_bc",    b_bc,    ph - 1);
        chk("rr_data",  b_fdata, 8'hD0 + 8'(g));
        chk("rr_ready", b_ready, 4'b0001 << g);
      end
      @(posedge clk_in); #1;
    end
    b_valid = '0;

    // NUM_REQ=3, valid=101 from reset (last_id=2): grants 0, 2, 0.
    c_valid = 3'b101;
    for (int c = 0; c <= 8; c++) begin
      ph   = c % 3;
      e_we = (ph != 0);
      #1;
      chk("n3_we", c_we, e_we);
      if (e_we) begin
        chk("n3_gid",   c_gid,   ord[c / 3]);
        chk("n3_data",  c_fdata, 8'hC0 + 8'(ord[c / 3]));
        chk("n3_ready", c_ready, 3'b001 << ord[c / 3]);
      end
      @(posedge clk_in); #1;
    end
    c_valid = '0;

    // Backpressure: requester 1, 10 words, FIFO full for 5 cycles mid-burst.
    idx = 0;
    for (int c = 0; c <= 17; c++) begin
      a_valid       = (idx < 10) ? 4'b0010 : 4'b0000;
      a_data[15:8]  = 8'h10 + 8'(idx);
      a_full        = (c >= 4 && c <= 8);
      e_we   = (c >= 1 && c <= 3) || (c >= 9 && c <= 15);
      e_busy = (c >= 1 && c <= 16);
      #1;
      chk("bp_we",    a_we,    e_we);
      chk("bp_busy",  a_busy,  e_busy);
      chk("bp_ready", a_ready, (e_busy && !a_full) ? 4'b0010 : 4'b0000);
      if (c >= 1) chk("bp_bc", a_bc, idx);
      if (e_busy) chk("bp_gid", a_gid, 1);
      if (e_we) begin
        chk("bp_data", a_fdata, 8'h10 + 8'(idx));
        idx++;
      end
      @(posedge clk_in); #1;
    end
    a_full = 1'b0;

    // Early release: requester 2 drops after 3 beats, requester 0 waits.
    idx = 0;
    a_data[7:0] = 8'hA0;
    for (int c = 0; c <= 5; c++) begin
      a_valid       = 4'b0001 | ((idx < 3) ? 4'b0100 : 4'b0000);
      a_data[23:16] = 8'h20 + 8'(idx);
      e_we   = (c >= 1 && c <= 3);
      e_busy = (c >= 1 && c <= 4);
      #1;
      chk("er_we",    a_we,    e_we);
      chk("er_busy",  a_busy,  e_busy);
      chk("er_ready", a_ready, e_busy ? 4'b0100 : 4'b0000);
      if (c >= 1) chk("er_bc", a_bc, idx);
      if (e_busy) chk("er_gid", a_gid, 2);
      if (e_we) begin
        chk("er_data", a_fdata, 8'h20 + 8'(idx));
        idx++;
      end
      @(posedge clk_in); #1;
    end
    #1;
    chk("er_next_gid",   a_gid,   0);
    chk("er_next_busy",  a_busy,  1);
    chk("er_next_bc",    a_bc,    0);
    chk("er_next_we",    a_we,    1);
    chk("er_next_ready", a_ready, 4'b0001);
    chk("er_next_data",  a_fdata, 8'hA0);

    // Reset mid-burst at beat_cnt=7.
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk_in); #2;
      chk("mr_bc", a_bc, k);
      chk("mr_we", a_we, 1);
    end
    rst_in_n = 1'b0;
    a_valid  = 4'b0101;
    #1;
    chk("mr_rst_we",    a_we,    0);
    chk("mr_rst_ready", a_ready, 0);
    chk("mr_rst_busy",  a_busy,  0);
    chk("mr_rst_gid",   a_gid,   0);
    chk("mr_rst_bc",    a_bc,    0);
    @(posedge clk_in); #1;
    chk("mr_rst_edge_we",   a_we,   0);
    chk("mr_rst_edge_busy", a_busy, 0);
    rst_in_n = 1'b1;
    #1;
    chk("mr_bubble_busy", a_busy, 0);
    chk("mr_bubble_we",   a_we,   0);
    @(posedge clk_in); #2;
    chk("mr_after_gid",  a_gid,  0);
    chk("mr_after_busy", a_busy, 1);
    chk("mr_after_bc",   a_bc,   0);
    chk("mr_after_we",   a_we,   1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
